// File: rtl/input_port_irq_ctrl.sv
// Change-detect interrupt controller for the four-port input block: fixed-priority P0, round-robin P1..P3.
// Optional IRQ_MASK_EN adds a writable 4-bit interrupt mask (fixed to P0-only when undefined).
module input_port_irq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] p0_data,
    input  logic [WIDTH-1:0] p1_data,
    input  logic [WIDTH-1:0] p2_data,
    input  logic [WIDTH-1:0] p3_data,
    input  logic [1:0]       cpu_sel,
    input  logic             irq_ack,
    input  logic             irq_done,
`ifdef IRQ_MASK_EN
    input  logic             mask_we,
    input  logic [3:0]       mask_wdata,
`endif
    output logic [1:0]       sel_port,
    output logic             interrupt,
    output logic [1:0]       irq_port,
    output logic [3:0]       pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t                  state_q, state_d;
    logic [3:0][WIDTH-1:0]   data;
    logic [3:0][WIDTH-1:0]   prev_q, prev_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [3:0]              pending_q, pending_d;
    logic [3:0]              chg, clr, elig, mask;
    logic                    interrupt_q, interrupt_d;
    logic [1:0]              irq_port_q, irq_port_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic [1:0]              winner;

    assign data = {p3_data, p2_data, p1_data, p0_data};

`ifdef IRQ_MASK_EN
    logic [3:0] mask_q, mask_d;
    always_comb mask_d = mask_we ? mask_wdata : mask_q;
    assign mask = mask_q;
`else
    assign mask = 4'b0001;
`endif

    assign elig = pending_q & mask;

    always_comb begin
        chg = '0;
        for (int i = 0; i < 4; i++)
            chg[i] = prev_valid_q && (data[i] != prev_q[i]);
    end

    // Only consulted when elig is non-zero; with P0 clear, one of P1..P3 must be set,
    // so the last candidate in each scan order is the safe fallback.
    always_comb begin
        winner = 2'd0;
        if (!elig[0]) begin
            case (rr_ptr_q)
                2'd1:    winner = elig[2] ? 2'd2 : (elig[3] ? 2'd3 : 2'd1);
                2'd2:    winner = elig[3] ? 2'd3 : (elig[1] ? 2'd1 : 2'd2);
                default: winner = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd3);
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        interrupt_d  = interrupt_q;
        irq_port_d   = irq_port_q;
        rr_ptr_d     = rr_ptr_q;
        clr          = '0;
        prev_d       = data;
        prev_valid_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    irq_port_d  = winner;
                    interrupt_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    clr[irq_port_q] = 1'b1;
                    interrupt_d     = 1'b0;
                    state_d         = SERVICE;
                end
            end
            SERVICE: begin
                if (irq_done) begin
                    if (irq_port_q != 2'd0)
                        rr_ptr_d = irq_port_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A change in the same cycle as the ack keeps the port pending.
        pending_d = (pending_q & ~clr) | chg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            interrupt_q  <= 1'b0;
            irq_port_q   <= 2'd0;
            pending_q    <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            rr_ptr_q     <= 2'd3;
`ifdef IRQ_MASK_EN
            mask_q       <= 4'b0001;
`endif
        end else begin
            state_q      <= state_d;
            interrupt_q  <= interrupt_d;
            irq_port_q   <= irq_port_d;
            pending_q    <= pending_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            rr_ptr_q     <= rr_ptr_d;
`ifdef IRQ_MASK_EN
            mask_q       <= mask_d;
`endif
        end
    end

    assign sel_port  = (state_q == SERVICE) ? irq_port_q : cpu_sel;
    assign interrupt = interrupt_q;
    assign irq_port  = irq_port_q;
    assign pending   = pending_q;

endmodule

// File: doc/input_port_irq_ctrl.md
# input_port_irq_ctrl

Interrupt and port-select controller for the processor's four-port input block. It watches the registered values of ports P0–P3 and latches a pending flag whenever a port value changes. It then arbitrates among pending ports, with P0 at fixed highest priority and P1–P3 served round-robin, and raises `interrupt` to the processor. During service it forces the input mux select to the granted port. Otherwise it passes the processor's own port select through.

## Interface
Parameters:
- `WIDTH`, 8, width of each input port.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p0_data`, `p1_data`, `p2_data`, `p3_data`  in  WIDTH each  registered port values, taken from the port register outputs.
- `cpu_sel`  in  2  port the processor selects outside interrupt service.
- `irq_ack`  in  1  one-cycle interrupt acknowledge from the processor.
- `irq_done`  in  1  one-cycle end-of-service (return from interrupt).
- `mask_we`  in  1  mask register write strobe (only with `IRQ_MASK_EN`).
- `mask_wdata`  in  4  new mask value, bit i enables port i (only with `IRQ_MASK_EN`).
- `sel_port`  out  2  select to the input mux.
- `interrupt`  out  1  interrupt request to the processor; registered.
- `irq_port`  out  2  port being requested or serviced; registered.
- `pending`  out  4  pending-change flags, bit i for port i.

## Operation
- Change detect:
  - Per port, a `prev_i` register and a `prev_valid` bit.
  - `chg_i = prev_valid && (pi_data != prev_i)`.
  - `prev_i <= pi_data` every cycle; `prev_valid <= 1` one cycle after reset.
  - No change is ever flagged on the first cycle after reset.
- Pending:
  - `pending[i]` sets on `chg_i` and clears when port i is acknowledged.
  - If a set and a clear land in the same cycle, the set wins.
  - Pending flags record changes regardless of the mask.
- Eligible set: `pending & mask`.
- Arbitration:
  - P0 eligible → grant P0.
  - Otherwise scan P1..P3 starting after `rr_ptr`, wrapping 3→1.
  - `rr_ptr` updates to the granted port on `irq_done`, but only when the granted port ≠ 0.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if the eligible set is non-zero, latch the winner into `irq_port`, set `interrupt`=1, go to REQ.
  - REQ: hold `interrupt` and `irq_port` (no re-arbitration). On `irq_ack`, clear `pending[irq_port]`, set `interrupt`=0, go to SERVICE.
  - SERVICE: on `irq_done`, go to IDLE.
  - `irq_ack` is ignored outside REQ; `irq_done` is ignored outside SERVICE.
- `sel_port` (combinational from state) = `irq_port` in SERVICE, else `cpu_sel`.
- Reset values:
  - state IDLE, `interrupt` 0, `irq_port` 0, `pending` 0.
  - `prev_i` 0, `prev_valid` 0, `rr_ptr` 3 (so P1 is first in the round-robin).
  - `sel_port` = `cpu_sel`.
- Reset mid-operation (any state) aborts service and discards all pending flags.

## Timing
- Port value changes at edge N (visible at `pi_data` during cycle N). Then:
  - `pending[i]` is 1 after edge N+1.
  - `interrupt` is 1 after edge N+2, provided the FSM is in IDLE and the port is unmasked.
- `irq_ack` sampled at edge M: after M, `interrupt`=0, the pending bit is clear, and `sel_port`=`irq_port`.
- `irq_done` sampled at edge K: after K, `sel_port`=`cpu_sel`. The earliest next `interrupt` is after edge K+1.
- `interrupt` is high exactly while in REQ.
- A change arriving during REQ or SERVICE only sets pending; it is served after return to IDLE.
- A change on the port currently in service after ack re-pends that port.

## Configuration
- `IRQ_MASK_EN` defined:
  - `mask_we`/`mask_wdata` ports and a 4-bit mask register exist; mask resets to 4'b0001.
  - `mask_we` loads `mask_wdata` at the edge, effective for arbitration the next cycle.
  - A write during REQ does not withdraw the current request.
- `IRQ_MASK_EN` undefined:
  - Mask ports are absent and the mask is fixed at 4'b0001, so only P0 interrupts.
  - P1–P3 still flag `pending`.

## Test plan
- Reset, then hold all ports constant for 10 cycles → `pending`=0, `interrupt`=0, `sel_port` tracks `cpu_sel`=2'd2.
- `p0_data` 0x00→0x5A → `pending`=4'b0001 after 1 edge, then `interrupt`=1 and `irq_port`=0 after 2 edges. `irq_ack` → `interrupt`=0, `sel_port`=0. `irq_done` → `sel_port`=`cpu_sel`.
- With `IRQ_MASK_EN`, mask 4'b1111, P1, P2, P3 and P0 change in the same cycle → service order P0, P1, P2, P3. A second simultaneous P1/P2/P3 change → order P1, P2, P3 (round-robin resumes after P3).
- `p2_data` changes again during SERVICE of P2 → after `irq_done`, P2 is re-requested 2 cycles later (`pending[2]`=1 throughout).
- `irq_ack` in IDLE and `irq_done` in REQ → no state change, `interrupt` unchanged.
- Assert `reset` during SERVICE with `pending`=4'b0110 → next cycle: IDLE, `pending`=0, `interrupt`=0, and no spurious interrupt in the first cycle after reset.
